// File: rtl/ssdisp_scan_if.sv
// Bus between the datapath/display side and the seven-segment scanner.
// The master loads values; the slave (ssdisp_scan) drives the decoder and digit selects.
interface ssdisp_scan_if #(
    parameter int DIGITS = 4
) ();
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  pending;
    logic [3:0]            nibble;
    logic                  dig_en;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output load, value,
        input  pending, nibble, dig_en, an, frame_done
    );

    modport slave (
        input  load, value,
        output pending, nibble, dig_en, an, frame_done
    );
endinterface

// File: rtl/ssdisp_scan.sv
// Time-multiplexed seven-segment scanner with a double-buffered display value.
// Define SSDISP_SCAN_LZB_EN to build leading-zero blanking on dig_en.
module ssdisp_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic         clk,
    input  logic         rst,
    ssdisp_scan_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    logic [PW-1:0]     pc;
    logic [IW-1:0]     idx;
    logic [VW-1:0]     pbuf;
    logic [VW-1:0]     dbuf;
    logic              pend;
    logic [3:0]        nibble_q;
    logic              dig_en_q;
    logic [DIGITS-1:0] an_q;
    logic              frame_done_q;

    logic              tick;
    logic              boundary;
    logic [IW-1:0]     idx_nx;
    logic [VW-1:0]     dbuf_nx;
    logic [3:0]        nibble_nx;
    logic [DIGITS-1:0] an_nx;
    logic              dig_en_nx;

    assign bus.pending    = pend;
    assign bus.nibble     = nibble_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

    // Outputs are registered from next-state idx/dbuf so select and digit switch on the same edge.
    // NOTE: every variable gets a default at the top of always_comb, so no latch is inferred.
    always_comb begin
        tick     = (pc == PW'(PRESCALE - 1));
        boundary = tick && (idx == IW'(DIGITS - 1));

        idx_nx = idx;
        if (tick) begin
            idx_nx = boundary ? '0 : idx + IW'(1);
        end

        // A load landing on the boundary bypasses pbuf and goes straight to the display.
        dbuf_nx = dbuf;
        if (boundary) begin
            if (bus.load) begin
                dbuf_nx = bus.value;
            end else if (pend) begin
                dbuf_nx = pbuf;
            end
        end

        nibble_nx = 4'd0;
        an_nx     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nx == IW'(i)) begin
                nibble_nx = dbuf_nx[4*i +: 4];
                an_nx[i]  = 1'b1;
            end
        end
    end

`ifdef SSDISP_SCAN_LZB_EN
    logic [DIGITS-1:0] upper_nz;
    logic              nz;

    // upper_nz[i] is set when any of digits i..DIGITS-1 is non-zero.
    always_comb begin
        upper_nz  = '0;
        nz        = 1'b0;
        dig_en_nx = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz          = nz | (dbuf_nx[4*i +: 4] != 4'd0);
            upper_nz[i] = nz;
        end
        for (int i = 1; i < DIGITS; i++) begin
            if (idx_nx == IW'(i)) begin
                dig_en_nx = upper_nz[i];
            end
        end
    end
`else
    assign dig_en_nx = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffers are plain registers, so they are cleared by reset like any state.
            pc           <= '0;
            idx          <= '0;
            pbuf         <= '0;
            dbuf         <= '0;
            pend         <= 1'b0;
            nibble_q     <= 4'd0;
            dig_en_q     <= 1'b1;
            an_q         <= DIGITS'(1);
            frame_done_q <= 1'b0;
        end else begin
            pc           <= tick ? '0 : pc + PW'(1);
            idx          <= idx_nx;
            dbuf         <= dbuf_nx;
            if (bus.load) begin
                pbuf <= bus.value;
            end
            if (bus.load) begin
                pend <= !boundary;
            end else if (boundary) begin
                pend <= 1'b0;
            end
            nibble_q     <= nibble_nx;
            dig_en_q     <= dig_en_nx;
            an_q         <= an_nx;
            frame_done_q <= boundary;
        end
    end
endmodule
